cci_mpf_svc_vtp_req_arbiter: RTL

// - Shares one VTP translation service among N_CLIENTS VTP pipeline shims.
// - Round-robin arbitrates lookup requests and remaps each client tag to a free service tag (pool of MAX_SVC_REQS).
// - Routes out-of-order service responses back to the issuing client with the client's original tag restored.
// - Sits between the per-shim client ports and the single service port of the translation service.

---
 rtl/cci_mpf_svc_vtp_req_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cci_mpf_svc_vtp_req_arbiter.sv
// rtl/cci_mpf_svc_vtp_req_arbiter.sv - round-robin VTP lookup arbiter with service tag remap
// Shares one translation service among N shims and routes out-of-order responses home.
module cci_mpf_svc_vtp_req_arbiter #(
    parameter int N_CLIENTS    = 4,
    parameter int VA_BITS      = 36,
    parameter int PA_BITS      = 36,
    parameter int MAX_SVC_REQS = 16,
    parameter int TAG_BITS     = $clog2(MAX_SVC_REQS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_CLIENTS-1:0]          cli_lookup_en,
    input  logic [N_CLIENTS*VA_BITS-1:0]  cli_lookup_va,
    input  logic [N_CLIENTS*TAG_BITS-1:0] cli_lookup_tag,
    output logic [N_CLIENTS-1:0]          cli_lookup_rdy,
    output logic [N_CLIENTS-1:0]          cli_rsp_valid,
    output logic [PA_BITS-1:0]            cli_rsp_pa,
    output logic [TAG_BITS-1:0]           cli_rsp_tag,
    output logic                          cli_rsp_big,
    output logic                          svc_lookup_en,
    output logic [VA_BITS-1:0]            svc_lookup_va,
    output logic [TAG_BITS-1:0]           svc_lookup_tag,
    input  logic                          svc_lookup_rdy,
    input  logic                          svc_rsp_valid,
    input  logic [PA_BITS-1:0]            svc_rsp_pa,
    input  logic [TAG_BITS-1:0]           svc_rsp_tag,
    input  logic                          svc_rsp_big,
    output logic [TAG_BITS:0]             tags_busy,
    output logic                          err_bad_rsp
);
    localparam int CLI_BITS = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    logic [MAX_SVC_REQS-1:0] busy_q, busy_d;
    logic [CLI_BITS-1:0]     tbl_cli_q [MAX_SVC_REQS];
    logic [CLI_BITS-1:0]     tbl_cli_d [MAX_SVC_REQS];
    logic [TAG_BITS-1:0]     tbl_tag_q [MAX_SVC_REQS];
    logic [TAG_BITS-1:0]     tbl_tag_d [MAX_SVC_REQS];
    logic                    out_vld_q, out_vld_d;
    logic [VA_BITS-1:0]      out_va_q, out_va_d;
    logic [TAG_BITS-1:0]     out_tag_q, out_tag_d;
    logic [CLI_BITS-1:0]     rr_q, rr_d;
    logic [N_CLIENTS-1:0]    rsp_vld_q, rsp_vld_d;
    logic [PA_BITS-1:0]      rsp_pa_q, rsp_pa_d;
    logic [TAG_BITS-1:0]     rsp_tag_q, rsp_tag_d;
    logic                    rsp_big_q, rsp_big_d;
    logic                    err_q, err_d;
    logic [TAG_BITS:0]       cnt_q, cnt_d;

    logic                    found;
    logic [CLI_BITS-1:0]     winner;
    logic [TAG_BITS-1:0]     alloc_tag;
    logic                    can_acc;
    logic                    grant;
    logic                    rsp_hit;

    always_comb begin
        found     = 1'b0;
        winner    = '0;
        alloc_tag = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            if (!found && cli_lookup_en[(int'(rr_q) + k) % N_CLIENTS]) begin
                found  = 1'b1;
                winner = CLI_BITS'((int'(rr_q) + k) % N_CLIENTS);
            end
        end
        // Scan downward so the last hit is the lowest free index.
        for (int t = MAX_SVC_REQS - 1; t >= 0; t--) begin
            if (!busy_q[t]) begin
                alloc_tag = TAG_BITS'(t);
            end
        end
        can_acc        = !(&busy_q) && (!out_vld_q || svc_lookup_rdy);
        grant          = reset_n && can_acc && found;
        cli_lookup_rdy = grant ? (N_CLIENTS'(1) << winner) : '0;
        // Only a tag already busy before this edge can be freed, so it never collides with alloc_tag.
        rsp_hit        = svc_rsp_valid && busy_q[svc_rsp_tag];
    end

    always_comb begin
        busy_d    = busy_q;
        tbl_cli_d = tbl_cli_q;
        tbl_tag_d = tbl_tag_q;
        out_vld_d = out_vld_q && !svc_lookup_rdy;
        out_va_d  = out_va_q;
        out_tag_d = out_tag_q;
        rr_d      = rr_q;
        if (grant) begin
            busy_d[alloc_tag]    = 1'b1;
            tbl_cli_d[alloc_tag] = winner;
            tbl_tag_d[alloc_tag] = cli_lookup_tag[int'(winner) * TAG_BITS +: TAG_BITS];
            out_vld_d            = 1'b1;
            out_va_d             = cli_lookup_va[int'(winner) * VA_BITS +: VA_BITS];
            out_tag_d            = alloc_tag;
            rr_d                 = (int'(winner) == N_CLIENTS - 1) ? '0 : winner + 1'b1;
        end
        if (rsp_hit) begin
            busy_d[svc_rsp_tag] = 1'b0;
        end
        rsp_vld_d = rsp_hit ? (N_CLIENTS'(1) << tbl_cli_q[svc_rsp_tag]) : '0;
        rsp_tag_d = tbl_tag_q[svc_rsp_tag];
        rsp_pa_d  = svc_rsp_pa;
        rsp_big_d = svc_rsp_big;
        err_d     = err_q || (svc_rsp_valid && !busy_q[svc_rsp_tag]);
        case ({grant, rsp_hit})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q    <= '0;
            out_vld_q <= 1'b0;
            out_va_q  <= '0;
            out_tag_q <= '0;
            rr_q      <= '0;
            rsp_vld_q <= '0;
            rsp_pa_q  <= '0;
            rsp_tag_q <= '0;
            rsp_big_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            busy_q    <= busy_d;
            out_vld_q <= out_vld_d;
            out_va_q  <= out_va_d;
            out_tag_q <= out_tag_d;
            rr_q      <= rr_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_pa_q  <= rsp_pa_d;
            rsp_tag_q <= rsp_tag_d;
            rsp_big_q <= rsp_big_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Table contents are only meaningful under a busy bit, so they carry no reset.
    always_ff @(posedge clk) begin
        tbl_cli_q <= tbl_cli_d;
        tbl_tag_q <= tbl_tag_d;
    end

    assign svc_lookup_en  = out_vld_q;
    assign svc_lookup_va  = out_va_q;
    assign svc_lookup_tag = out_tag_q;
    assign cli_rsp_valid  = rsp_vld_q;
    assign cli_rsp_pa     = rsp_pa_q;
    assign cli_rsp_tag    = rsp_tag_q;
    assign cli_rsp_big    = rsp_big_q;
    assign tags_busy      = cnt_q;
    assign err_bad_rsp    = err_q;
endmodule
